// File: rtl/snax_cgra_pkg.sv
// Shared types for the CGRA data-memory port to SNAX TCDM adapter.
// CGRA payload bundle, adapter FSM states and write strobe constant.
package snax_cgra_pkg;

  localparam int unsigned PayloadWidth = 16;
  localparam logic [1:0] StrbLow = 2'b11;

  typedef struct packed {
    logic [PayloadWidth-1:0] payload;
    logic                    predicate;
    logic                    bypass;
  } cgra_data_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT,
    RD_SEND
  } adapter_state_e;

endpackage

// File: rtl/snax_cgra_hold_reg.sv
// One-entry en/rdy holding register; rdy is low while full or in reset.
// Cleared by the owner once the held entry has been consumed.
module snax_cgra_hold_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] msg_i,
  input  logic             clr_i,
  output logic             rdy_o,
  output logic             full_o,
  output logic [Width-1:0] data_o
);

  logic             full_q;
  logic [Width-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else if (en_i && !full_q) begin
      full_q <= 1'b1;
      data_q <= msg_i;
    end
  end

  assign rdy_o  = rst_ni & ~full_q;
  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/snax_cgra_tcdm_adapter.sv
// Bridges one CGRA data-memory port to one SNAX TCDM reqrsp port.
// Optional perf counters: define SNAX_CGRA_TCDM_PERF_CNT_EN.
module snax_cgra_tcdm_adapter
  import snax_cgra_pkg::*;
#(
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TCDMAddrWidth = 48,
  parameter int unsigned AddrWidth     = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [TCDMAddrWidth-1:0] base_addr_i,
  input  logic                     waddr_en_i,
  input  logic [AddrWidth-1:0]     waddr_msg_i,
  output logic                     waddr_rdy_o,
  input  logic                     wdata_en_i,
  input  cgra_data_t               wdata_msg_i,
  output logic                     wdata_rdy_o,
  input  logic                     raddr_en_i,
  input  logic [AddrWidth-1:0]     raddr_msg_i,
  output logic                     raddr_rdy_o,
  output logic                     rdata_en_o,
  output cgra_data_t               rdata_msg_o,
  input  logic                     rdata_rdy_i,
  output logic [TCDMAddrWidth-1:0] tcdm_req_addr_o,
  output logic                     tcdm_req_write_o,
  output logic [DataWidth-1:0]     tcdm_req_data_o,
  output logic [DataWidth/8-1:0]   tcdm_req_strb_o,
  output logic                     tcdm_req_q_valid_o,
  input  logic                     tcdm_rsp_q_ready_i,
  input  logic                     tcdm_rsp_p_valid_i,
  input  logic [DataWidth-1:0]     tcdm_rsp_data_i,
`ifdef SNAX_CGRA_TCDM_PERF_CNT_EN
  output logic [31:0]              wr_cnt_o,
  output logic [31:0]              rd_cnt_o,
  output logic [31:0]              stall_cnt_o,
`endif
  output logic                     busy_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned ByteShift = $clog2(StrbWidth);

  adapter_state_e state_q, state_d;

  logic                     waddr_full, wdata_full, wr_clr;
  logic [AddrWidth-1:0]     waddr_q;
  cgra_data_t               wdata_q;
  logic                     ld_wr, ld_rd, q_hs;
  logic [TCDMAddrWidth-1:0] addr_q, wr_addr, rd_addr;
  logic [PayloadWidth-1:0]  rd_payload_q;
  cgra_data_t               rd_msg;

  snax_cgra_hold_reg #(
    .Width (AddrWidth)
  ) i_waddr_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (waddr_en_i),
    .msg_i  (waddr_msg_i),
    .clr_i  (wr_clr),
    .rdy_o  (waddr_rdy_o),
    .full_o (waddr_full),
    .data_o (waddr_q)
  );

  snax_cgra_hold_reg #(
    .Width ($bits(cgra_data_t))
  ) i_wdata_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (wdata_en_i),
    .msg_i  (wdata_msg_i),
    .clr_i  (wr_clr),
    .rdy_o  (wdata_rdy_o),
    .full_o (wdata_full),
    .data_o (wdata_q)
  );

  // Word to byte address; the sum wraps at TCDMAddrWidth.
  assign wr_addr = base_addr_i
                 + (TCDMAddrWidth'(waddr_q) << ByteShift);
  assign rd_addr = base_addr_i
                 + (TCDMAddrWidth'(raddr_msg_i) << ByteShift);

  // A pending or partially received write blocks new reads.
  assign raddr_rdy_o = rst_ni & (state_q == IDLE)
                     & ~waddr_full & ~wdata_full;

  always_comb begin
    state_d            = state_q;
    wr_clr             = 1'b0;
    ld_wr              = 1'b0;
    ld_rd              = 1'b0;
    tcdm_req_q_valid_o = 1'b0;
    rdata_en_o         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (waddr_full && wdata_full) begin
          if (wdata_q.predicate) begin
            state_d = WR_REQ;
            ld_wr   = 1'b1;
          end else begin
            wr_clr = 1'b1;
          end
        end else if (raddr_en_i && raddr_rdy_o) begin
          state_d = RD_REQ;
          ld_rd   = 1'b1;
        end
      end
      WR_REQ: begin
        tcdm_req_q_valid_o = 1'b1;
        if (tcdm_rsp_q_ready_i) begin
          wr_clr  = 1'b1;
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        tcdm_req_q_valid_o = 1'b1;
        if (tcdm_rsp_q_ready_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (tcdm_rsp_p_valid_i) state_d = RD_SEND;
      end
      RD_SEND: begin
        rdata_en_o = rdata_rdy_i;
        if (rdata_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rd_payload_q <= '0;
    end else begin
      state_q <= state_d;
      if (ld_wr) addr_q <= wr_addr;
      if (ld_rd) addr_q <= rd_addr;
      if (state_q == RD_WAIT && tcdm_rsp_p_valid_i)
        rd_payload_q <= tcdm_rsp_data_i[PayloadWidth-1:0];
    end
  end

  always_comb begin
    rd_msg = '0;
    if (state_q == RD_SEND) begin
      rd_msg.payload   = rd_payload_q;
      rd_msg.predicate = 1'b1;
    end
  end

  assign rdata_msg_o      = rd_msg;
  assign tcdm_req_addr_o  = addr_q;
  assign tcdm_req_write_o = (state_q == WR_REQ);
  assign tcdm_req_data_o  = tcdm_req_write_o
    ? {{(DataWidth-PayloadWidth){1'b0}}, wdata_q.payload}
    : '0;
  assign tcdm_req_strb_o  = tcdm_req_write_o
    ? {{(StrbWidth-2){1'b0}}, StrbLow}
    : '0;
  assign busy_o = (state_q != IDLE) | waddr_full | wdata_full;
  assign q_hs   = tcdm_req_q_valid_o & tcdm_rsp_q_ready_i;

  logic unused_bits;
  assign unused_bits = ^{tcdm_rsp_data_i[DataWidth-1:PayloadWidth],
                         wdata_q.bypass, q_hs};

`ifdef SNAX_CGRA_TCDM_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_o    <= '0;
      rd_cnt_o    <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (q_hs && tcdm_req_write_o && wr_cnt_o != '1)
        wr_cnt_o <= wr_cnt_o + 32'd1;
      if (q_hs && !tcdm_req_write_o && rd_cnt_o != '1)
        rd_cnt_o <= rd_cnt_o + 32'd1;
      if (tcdm_req_q_valid_o && !tcdm_rsp_q_ready_i
          && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snax_cgra_tcdm_adapter.sv
// Scoreboard bench for snax_cgra_tcdm_adapter: expected TCDM requests
// and CGRA read responses are queued at stimulus time, checked on output.
module tb_snax_cgra_tcdm_adapter;
  import snax_cgra_pkg::*;

  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [63:0] data;
    logic [7:0]  strb;
  } req_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [47:0] base_addr_i;
  logic        waddr_en_i;
  logic [5:0]  waddr_msg_i;
  logic        waddr_rdy_o;
  logic        wdata_en_i;
  cgra_data_t  wdata_msg_i;
  logic        wdata_rdy_o;
  logic        raddr_en_i;
  logic [5:0]  raddr_msg_i;
  logic        raddr_rdy_o;
  logic        rdata_en_o;
  cgra_data_t  rdata_msg_o;
  logic        rdata_rdy_i;
  logic [47:0] tcdm_req_addr_o;
  logic        tcdm_req_write_o;
  logic [63:0] tcdm_req_data_o;
  logic [7:0]  tcdm_req_strb_o;
  logic        tcdm_req_q_valid_o;
  logic        tcdm_rsp_q_ready_i;
  logic        tcdm_rsp_p_valid_i;
  logic [63:0] tcdm_rsp_data_i;
  logic        busy_o;
`ifdef SNAX_CGRA_TCDM_PERF_CNT_EN
  logic [31:0] wr_cnt_o, rd_cnt_o, stall_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_cnt  = 0;
  int hs_cyc  = 0;
  int rd_cnt  = 0;
  int stall_seen = 0;

  req_t       req_q[$];
  cgra_data_t rdq[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  snax_cgra_tcdm_adapter dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .base_addr_i        (base_addr_i),
    .waddr_en_i         (waddr_en_i),
    .waddr_msg_i        (waddr_msg_i),
    .waddr_rdy_o        (waddr_rdy_o),
    .wdata_en_i         (wdata_en_i),
    .wdata_msg_i        (wdata_msg_i),
    .wdata_rdy_o        (wdata_rdy_o),
    .raddr_en_i         (raddr_en_i),
    .raddr_msg_i        (raddr_msg_i),
    .raddr_rdy_o        (raddr_rdy_o),
    .rdata_en_o         (rdata_en_o),
    .rdata_msg_o        (rdata_msg_o),
    .rdata_rdy_i        (rdata_rdy_i),
    .tcdm_req_addr_o    (tcdm_req_addr_o),
    .tcdm_req_write_o   (tcdm_req_write_o),
    .tcdm_req_data_o    (tcdm_req_data_o),
    .tcdm_req_strb_o    (tcdm_req_strb_o),
    .tcdm_req_q_valid_o (tcdm_req_q_valid_o),
    .tcdm_rsp_q_ready_i (tcdm_rsp_q_ready_i),
    .tcdm_rsp_p_valid_i (tcdm_rsp_p_valid_i),
    .tcdm_rsp_data_i    (tcdm_rsp_data_i),
`ifdef SNAX_CGRA_TCDM_PERF_CNT_EN
    .wr_cnt_o           (wr_cnt_o),
    .rd_cnt_o           (rd_cnt_o),
    .stall_cnt_o        (stall_cnt_o),
`endif
    .busy_o             (busy_o)
  );

  // Output monitor: pops the scoreboard on every handshake.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (tcdm_req_q_valid_o && !tcdm_rsp_q_ready_i)
        stall_seen++;
      if (tcdm_req_q_valid_o && tcdm_rsp_q_ready_i) begin
        req_t e;
        req_t a;
        hs_cnt++;
        hs_cyc = cyc;
        n_tests++;
        a = {tcdm_req_addr_o, tcdm_req_write_o,
             tcdm_req_data_o, tcdm_req_strb_o};
        if (req_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_req got=%h", a);
        end else begin
          e = req_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL tcdm_req got=%h exp=%h", a, e);
          end
        end
      end
      if (rdata_en_o) begin
        cgra_data_t e;
        rd_cnt++;
        n_tests++;
        if (rdq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rdata got=%h", rdata_msg_o);
        end else begin
          e = rdq.pop_front();
          if (rdata_msg_o !== e) begin
            n_fail++;
            $display("FAIL rdata got=%h exp=%h", rdata_msg_o, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_hs(input int target);
    for (int k = 0; k < 40 && hs_cnt < target; k++) @(negedge clk_i);
    if (hs_cnt < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL hs_timeout got=%0d exp=%0d", hs_cnt, target);
    end
  endtask

  task automatic wait_rd(input int target);
    for (int k = 0; k < 40 && rd_cnt < target; k++) @(negedge clk_i);
    if (rd_cnt < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL rd_timeout got=%0d exp=%0d", rd_cnt, target);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [170:0] v;
    v = {waddr_rdy_o, wdata_rdy_o, raddr_rdy_o, rdata_en_o,
         rdata_msg_o, tcdm_req_addr_o, tcdm_req_write_o,
         tcdm_req_data_o, tcdm_req_strb_o, tcdm_req_q_valid_o,
         busy_o};
    n_tests++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL %s outputs got=%h exp=0", name, v);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    base_addr_i = 48'h1000;
    waddr_en_i = 0; waddr_msg_i = 0;
    wdata_en_i = 0; wdata_msg_i = '0;
    raddr_en_i = 0; raddr_msg_i = 0;
    rdata_rdy_i = 0;
    tcdm_rsp_q_ready_i = 0;
    tcdm_rsp_p_valid_i = 0;
    tcdm_rsp_data_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if ({waddr_rdy_o, wdata_rdy_o, raddr_rdy_o, busy_o} !== 4'b1110) begin
      n_fail++;
      $display("FAIL post_reset rdy/busy got=%b exp=1110",
               {waddr_rdy_o, wdata_rdy_o, raddr_rdy_o, busy_o});
    end
  endtask

  task automatic test_write();
    int n0, h0;
    base_addr_i = 48'h1000;
    tcdm_rsp_q_ready_i = 1;
    tick();
    waddr_en_i = 1; waddr_msg_i = 6'd5;
    tick();
    waddr_en_i = 0;
    tick();
    tick();
    wdata_en_i = 1; wdata_msg_i = '{16'hBEEF, 1'b1, 1'b0};
    req_q.push_back('{48'h1028, 1'b1, 64'hBEEF, 8'h03});
    n0 = cyc;
    h0 = hs_cnt;
    tick();
    wdata_en_i = 0;
    wait_hs(h0 + 1);
    n_tests++;
    if (hs_cyc !== n0 + 2) begin
      n_fail++;
      $display("FAIL write_latency got=%0d exp=2", hs_cyc - n0);
    end
  endtask

  task automatic test_drop();
    int h0;
    tick();
    waddr_en_i = 1; waddr_msg_i = 6'd7;
    wdata_en_i = 1; wdata_msg_i = '{16'h1111, 1'b0, 1'b0};
    h0 = hs_cnt;
    tick();
    waddr_en_i = 0; wdata_en_i = 0;
    @(negedge clk_i);
    n_tests++;
    if ({waddr_rdy_o, wdata_rdy_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_full got=%b exp=00", {waddr_rdy_o, wdata_rdy_o});
    end
    tick();
    @(negedge clk_i);
    n_tests++;
    if ({waddr_rdy_o, wdata_rdy_o, busy_o} !== 3'b110) begin
      n_fail++;
      $display("FAIL drop_release got=%b exp=110",
               {waddr_rdy_o, wdata_rdy_o, busy_o});
    end
    repeat (5) tick();
    n_tests++;
    if (hs_cnt !== h0) begin
      n_fail++;
      $display("FAIL drop_no_req got=%0d exp=%0d", hs_cnt, h0);
    end
  endtask

  task automatic test_read_stall();
    int s0, r0;
    base_addr_i = 48'h1000;
    tcdm_rsp_q_ready_i = 0;
    rdata_rdy_i = 1;
    tick();
    raddr_en_i = 1; raddr_msg_i = 6'd2;
    req_q.push_back('{48'h1010, 1'b0, 64'h0, 8'h0});
    s0 = stall_seen;
    r0 = rd_cnt;
    @(negedge clk_i);
    n_tests++;
    if (raddr_rdy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL raddr_rdy got=%b exp=1", raddr_rdy_o);
    end
    tick();
    raddr_en_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_tests++;
      if ({tcdm_req_q_valid_o, tcdm_req_write_o, tcdm_req_addr_o}
          !== {1'b1, 1'b0, 48'h1010}) begin
        n_fail++;
        $display("FAIL stall_req[%0d] got=%b/%b/%h exp=1/0/1010", i,
                 tcdm_req_q_valid_o, tcdm_req_write_o, tcdm_req_addr_o);
      end
      tick();
    end
    tcdm_rsp_q_ready_i = 1;
    tcdm_rsp_p_valid_i = 1;
    tcdm_rsp_data_i = 64'hDEAD;
    tick();
    tcdm_rsp_p_valid_i = 0;
    tick();
    tick();
    tcdm_rsp_p_valid_i = 1;
    tcdm_rsp_data_i = 64'hCAFE_0000_0000_1234;
    rdq.push_back('{16'h1234, 1'b1, 1'b0});
    tick();
    tcdm_rsp_p_valid_i = 0;
    wait_rd(r0 + 1);
    n_tests++;
    if (stall_seen - s0 !== 4) begin
      n_fail++;
      $display("FAIL stall_cycles got=%0d exp=4", stall_seen - s0);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    tcdm_rsp_q_ready_i = 1;
    rdata_rdy_i = 0;
    tick();
    raddr_en_i = 1; raddr_msg_i = 6'd3;
    req_q.push_back('{48'h1018, 1'b0, 64'h0, 8'h0});
    tick();
    raddr_en_i = 0;
    tick();
    tcdm_rsp_p_valid_i = 1;
    tcdm_rsp_data_i = 64'h5555_0000_0000_ABCD;
    rdq.push_back('{16'hABCD, 1'b1, 1'b0});
    r0 = rd_cnt;
    tick();
    tcdm_rsp_p_valid_i = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_tests++;
      if ({rdata_en_o, raddr_rdy_o, rdata_msg_o}
          !== {1'b0, 1'b0, 16'hABCD, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL hold[%0d] got=%b/%b/%h exp=0/0/abcd,1,0", i,
                 rdata_en_o, raddr_rdy_o, rdata_msg_o);
      end
      tick();
    end
    rdata_rdy_i = 1;
    @(negedge clk_i);
    n_tests++;
    if (rdata_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_first_rdy got=%b exp=1", rdata_en_o);
    end
    wait_rd(r0 + 1);
  endtask

  task automatic test_wrap();
    int h0;
    base_addr_i = 48'hFFFF_FFFF_FFF8;
    tcdm_rsp_q_ready_i = 1;
    tick();
    waddr_en_i = 1; waddr_msg_i = 6'd1;
    wdata_en_i = 1; wdata_msg_i = '{16'h55AA, 1'b1, 1'b1};
    req_q.push_back('{48'h0, 1'b1, 64'h55AA, 8'h03});
    h0 = hs_cnt;
    tick();
    waddr_en_i = 0; wdata_en_i = 0;
    wait_hs(h0 + 1);
  endtask

  task automatic test_reset_mid();
    base_addr_i = 48'h1000;
    tcdm_rsp_q_ready_i = 1;
    rdata_rdy_i = 1;
    tick();
    raddr_en_i = 1; raddr_msg_i = 6'd4;
    req_q.push_back('{48'h1020, 1'b0, 64'h0, 8'h0});
    tick();
    raddr_en_i = 0;
    tick();
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_all_zero("mid_reset");
    tick();
    rst_ni = 1'b1;
    tcdm_rsp_p_valid_i = 1;
    tcdm_rsp_data_i = 64'h7777;
    tick();
    tcdm_rsp_p_valid_i = 0;
    @(negedge clk_i);
    n_tests++;
    if ({busy_o, rdata_en_o, tcdm_req_q_valid_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL late_rsp got=%b exp=000",
               {busy_o, rdata_en_o, tcdm_req_q_valid_o});
    end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_drop();
    test_read_stall();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    n_tests++;
    if (req_q.size() + rdq.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_left got=%0d/%0d exp=0/0",
               req_q.size(), rdq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snax_cgra_tcdm_adapter.md
Name: snax_cgra_tcdm_adapter

Overview:
Per-port bridge between one CGRA data-memory port (PyMTL en/rdy, 16-bit payload, predicate, bypass) and one SNAX TCDM reqrsp port. It sits directly downstream of the CGRA array, and the wrapper instantiates one per TCDM port (SnaxTcdmPorts copies). It serialises write and read requests and translates CGRA word addresses to TCDM byte addresses. It holds read data until the CGRA accepts it.

Parameters:
DataWidth, 64, TCDM data width in bits
TCDMAddrWidth, 48, TCDM byte-address width
AddrWidth, 6, CGRA word-address width
PayloadWidth, 16, CGRA payload width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
base_addr_i  in  TCDMAddrWidth  TCDM byte base of this port's region; quasi-static, sampled at request issue
waddr_en_i  in  1  write-address transfer (only when waddr_rdy_o=1)
waddr_msg_i  in  AddrWidth  write word address
waddr_rdy_o  out  1  write-address slot free
wdata_en_i  in  1  write-data transfer
wdata_msg_i  in  PayloadWidth+2  {payload, predicate, bypass}
wdata_rdy_o  out  1  write-data slot free
raddr_en_i  in  1  read-address transfer
raddr_msg_i  in  AddrWidth  read word address
raddr_rdy_o  out  1  read request accepted
rdata_en_o  out  1  read-data transfer to CGRA
rdata_msg_o  out  PayloadWidth+2  {payload, predicate, bypass}
rdata_rdy_i  in  1  CGRA can take read data
tcdm_req_addr_o  out  TCDMAddrWidth  byte address
tcdm_req_write_o  out  1  1=write
tcdm_req_data_o  out  DataWidth  write data
tcdm_req_strb_o  out  DataWidth/8  byte strobe
tcdm_req_q_valid_o  out  1  request valid
tcdm_rsp_q_ready_i  in  1  request accepted
tcdm_rsp_p_valid_i  in  1  read response valid
tcdm_rsp_data_i  in  DataWidth  read response data
busy_o  out  1  state != IDLE or any holding register full

Behaviour:
- Reset: every output is 0, FSM is IDLE, the waddr and wdata holding registers are empty, and all rdy outputs are 0 during reset.
- Address rule: tcdm_addr = base_addr_i + (word_addr << log2(DataWidth/8)), truncated to TCDMAddrWidth so that overflow wraps silently.
- Write data: payload is zero-extended to DataWidth and strb = 2'b11 (low PayloadWidth/8 bytes only).
- waddr and wdata may arrive in any order or in the same cycle. Each has a one-entry holding register. rdy_o = register empty.
- FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_SEND.
- IDLE -> WR_REQ when both write registers are full and the held predicate = 1.
  - If the held predicate = 0, both registers are cleared in that cycle and no TCDM request is made. The write is dropped; this is a consume.
- IDLE -> RD_REQ on raddr_en_i.
  - raddr_rdy_o = 1 only in IDLE with both write registers empty, so a pending write has priority.
  - The read address is registered.
- WR_REQ: q_valid_o = 1 and write = 1, with addr, data and strb stable until tcdm_rsp_q_ready_i. On handshake, clear the registers and go to IDLE. Minimum latency from the second of waddr/wdata to q handshake is 2 cycles.
- RD_REQ: q_valid_o = 1 and write = 0. On handshake go to RD_WAIT. If p_valid_i arrives in the same cycle as the handshake, it is ignored; the response is always at least 1 cycle later.
- RD_WAIT: on p_valid_i, capture data[PayloadWidth-1:0] and go to RD_SEND.
- RD_SEND: rdata_msg_o = {captured payload, predicate=1, bypass=0}, and rdata_en_o = rdata_rdy_i. The cycle rdata_en_o = 1 returns the FSM to IDLE. Data is held indefinitely while rdata_rdy_i = 0.
- q_valid_o is never deasserted before its handshake, and request fields do not change while valid.
- p_valid_i outside RD_WAIT is ignored.
- Reset mid-operation: outstanding requests and held data are discarded. A late TCDM response after reset is ignored because the FSM is in IDLE.
- One outstanding transaction at a time; no pipelining.

Optional Feature:
SNAX_CGRA_TCDM_PERF_CNT_EN.
- Defined: three extra 32-bit outputs. wr_cnt_o counts write q handshakes. rd_cnt_o counts read q handshakes. stall_cnt_o counts cycles with q_valid_o=1 and q_ready_i=0. All three saturate at 2^32-1 and reset to 0.
- Undefined: the ports and logic are absent, and functional behaviour is identical.

Decomposition:
- Package snax_cgra_pkg holds:
  - the CGRAData payload/predicate/bypass struct, typedef cgra_data_t;
  - the adapter state enum;
  - PayloadWidth and the strobe constant.
- Sub-module snax_cgra_hold_reg: a one-entry en/rdy holding register, instantiated for waddr and for wdata.

Test Plan:
- base=0x1000; waddr 5 then wdata {0xBEEF,1,0} 3 cycles later, q_ready=1 -> single write at addr 0x1028, data 0xBEEF, strb 0x03, 2 cycles after wdata.
- wdata predicate=0, addr 7 -> no q_valid ever; waddr_rdy/wdata_rdy return to 1 the next cycle.
- read addr 2, q_ready held 0 for 4 cycles then 1, p_valid 3 cycles later with 0x...1234 -> stall of 4 cycles with stable addr 0x1010; rdata_msg {0x1234,1,0}.
- rdata_rdy_i=0 for 5 cycles in RD_SEND -> rdata_en_o stays 0, data held, raddr_rdy_o=0; accepted on the first rdy cycle.
- base=2^48-8, addr 1 -> tcdm_req_addr_o = 0 (wrap).
- rst_ni pulsed low in RD_WAIT, then p_valid arrives -> outputs 0, response ignored, busy_o=0.
